aes_round_pipe: RTL and testbench
=================================

Name: aes_round_pipe

Overview:
- Parametrised, handshaked successor to the single AES-128 encryption round datapath.
- Performs SubBytes, ShiftRows, MixColumns (skipped on final round, selected per transaction) and AddRoundKey.
- Pipeline depth is configurable; valid/ready flow control with full backpressure.
- A user tag travels alongside each block so the key-schedule/control FSM can track which round or block is in flight.

Parameters:
- PIPE_STAGES, 3, register stages 1..3. 1 = all logic then one register. 2 = register after SubBytes/ShiftRows, then after AddRoundKey. 3 = register after SubBytes/ShiftRows, after MixColumns, after AddRoundKey.
- TAG_W, 4, width of the sideband tag carried with each block (min 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  [0:15][7:0]  state, byte 4*c+r = column c, row r; byte 0 is the MSB.
- in_key  input  [0:3][31:0]  round key; word c XORs column c.
- in_final  input  1  1 = final round, MixColumns bypassed.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- out_data  output  [0:15][7:0]  round result.
- out_tag  output  TAG_W  tag of out_data.

Behaviour:
- Reset, synchronous active-high: all stage valid bits cleared; out_valid=0, out_data=0, out_tag=0; in_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards every in-flight block; nothing is emitted afterwards.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_key, in_final and in_tag are sampled with in_data and registered down the pipe. The key may change on the very next cycle.
- Each stage register holds valid, data, key, final and tag. A stage loads when its downstream is empty or advancing (bubble-collapsing).
  - Last stage advances when out_ready=1 or out_valid=0.
  - in_ready = stage-1 empty, or stage 1 advancing this cycle. This is combinational from out_ready through the chain; no skid buffer.
- Latency: an accepted block appears on out_valid exactly PIPE_STAGES cycles later with no stalls.
- Throughput: 1 block/cycle sustained when out_ready=1.
- Stalls: while out_valid=1 and out_ready=0, out_data/out_tag hold stable. Upstream stages keep filling until full, then in_ready=0.
- Ordering: strict FIFO; no reordering or drop; tags match their data.
- ShiftRows: out[4c+r] = in[4*((c+r) mod 4)+r].
- MixColumns: standard GF(2^8) matrix {02,03,01,01} rotated, xtime polynomial 0x11B. When final=1 the stage passes data through unchanged.
- AddRoundKey: byte 4c+r XOR key word c, byte r (byte 0 = bits 31:24).
- Pipeline with one free slot: simultaneous input and output transfer is legal in the same cycle.
- PIPE_STAGES outside 1..3 is an elaboration error.

Optional Feature:
- Macro AES_ROUND_PIPE_PERF_EN.
- When defined, adds outputs perf_blocks [31:0] and perf_stalls [31:0]. Both reset to 0.
  - perf_blocks increments on each output transfer.
  - perf_stalls increments each cycle out_valid=1 && out_ready=0.
  - Both saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- FIPS-197 B round 1, PIPE_STAGES=3, final=0, tag=5: in_data 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605 -> after 3 cycles out_data a49c7ff2689f352b6b5bea43026a5049, out_tag=5.
- Final round: in_data eb40f21e592e38848ba113e71bc342d2, key d014f9a8c9ee2589e13f0cc8b6630ca6, final=1 -> out_data 3925841d02dc09fbdc118597196a0b32. Repeat for PIPE_STAGES=1 and 2 with latency 1 and 2 respectively.
- Backpressure: stream 8 blocks with tags 0..7, out_ready low for cycles 4..9. Require:
  - in_ready drops once the 3 stages are full.
  - out_data held stable while stalled.
  - all 8 blocks emerge in order with correct tags and results.
  - perf_stalls equals the count of stalled-valid cycles (PERF_EN).
- Back-to-back alternating final=0/1 with key changing every cycle -> each result matches a golden model using its own sampled key and mode.
- Reset mid-stream with 2 blocks in flight: rst high 1 cycle -> out_valid=0 next cycle, no stale block emitted, in_ready=1; a fresh block afterwards yields a correct result.
- Counter saturation (PERF_EN, force perf_blocks=0xFFFFFFFE) -> two output transfers leave it at 0xFFFFFFFF.

Source files
------------

// File: rtl/aes_round_pipe.sv
// aes_round_pipe: one AES-128 encryption round, 1..3 register stages.
// Optional perf counters when AES_ROUND_PIPE_PERF_EN is defined.
module aes_round_pipe #(
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:15][7:0]   in_data,
  input  logic [0:3][31:0]   in_key,
  input  logic               in_final,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:15][7:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef AES_ROUND_PIPE_PERF_EN
  ,
  output logic [31:0]        perf_blocks,
  output logic [31:0]        perf_stalls
`endif
);

  typedef logic [0:15][7:0] blk_t;
  typedef logic [0:3][31:0] key_t;

  localparam int LAST  = PIPE_STAGES - 1;
  localparam int MC_ST = (PIPE_STAGES == 3) ? 1 : LAST;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
    $error("aes_round_pipe: PIPE_STAGES must be 1..3");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_round_pipe: TAG_W must be >= 1");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // Inverse as x^254 by square-and-multiply, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] v;
    p = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic blk_t sub_shift(input blk_t b);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = sbox(b[4*((c+r)%4)+r]);
    return o;
  endfunction

  function automatic blk_t mix(input blk_t b, input logic fin);
    blk_t o;
    o = b;
    if (!fin) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[4*c+r] = xt(b[4*c+r]) ^ xt(b[4*c+(r+1)%4])
                   ^ b[4*c+(r+1)%4] ^ b[4*c+(r+2)%4]
                   ^ b[4*c+(r+3)%4];
    end
    return o;
  endfunction

  function automatic blk_t ark(input blk_t b, input key_t k);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = b[4*c+r] ^ k[c][31-8*r -: 8];
    return o;
  endfunction

  logic [LAST:0]    r_v;
  blk_t             r_d [PIPE_STAGES];
  key_t             r_k [PIPE_STAGES];
  logic [LAST:0]    r_f;
  logic [TAG_W-1:0] r_t [PIPE_STAGES];

  logic [LAST:0]    w_ld;
  logic [LAST:0]    w_cv;
  logic [LAST:0]    w_cf;
  blk_t             w_cd [PIPE_STAGES];
  key_t             w_ck [PIPE_STAGES];
  logic [TAG_W-1:0] w_ct [PIPE_STAGES];
  blk_t             w_nd [PIPE_STAGES];

  // A stage may load if it or any stage below it has room
  always_comb begin : p_load
    logic acc;
    acc = out_ready;
    for (int s = LAST; s >= 0; s--) begin
      acc = acc || !r_v[s];
      w_ld[s] = acc;
    end
  end

  always_comb begin
    w_cv[0] = in_valid;
    w_cd[0] = in_data;
    w_ck[0] = in_key;
    w_cf[0] = in_final;
    w_ct[0] = in_tag;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      w_cv[s] = r_v[s-1];
      w_cd[s] = r_d[s-1];
      w_ck[s] = r_k[s-1];
      w_cf[s] = r_f[s-1];
      w_ct[s] = r_t[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++) begin
      w_nd[s] = w_cd[s];
      if (s == 0)     w_nd[s] = sub_shift(w_nd[s]);
      if (s == MC_ST) w_nd[s] = mix(w_nd[s], w_cf[s]);
      if (s == LAST)  w_nd[s] = ark(w_nd[s], w_ck[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_f <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_d[s] <= '0;
        r_k[s] <= '0;
        r_t[s] <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (w_ld[s]) begin
          r_v[s] <= w_cv[s];
          if (w_cv[s]) begin
            r_d[s] <= w_nd[s];
            r_k[s] <= w_ck[s];
            r_f[s] <= w_cf[s];
            r_t[s] <= w_ct[s];
          end
        end
      end
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_v[LAST];
  assign out_data  = r_d[LAST];
  assign out_tag   = r_t[LAST];

`ifdef AES_ROUND_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_stalls <= '0;
    end else begin
      if (out_valid && out_ready && perf_blocks != '1)
        perf_blocks <= perf_blocks + 32'd1;
      if (out_valid && !out_ready && perf_stalls != '1)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe: vector table, latency per depth, backpressure,
// random traffic and mid-stream reset against a table-based AES model.
module tb_aes_round_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_valid_s, in_final, out_ready;
  logic [127:0] in_data, in_key;
  logic [3:0]   in_tag;
  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
  logic         in_ready1, out_valid1, in_ready2, out_valid2;
  logic [127:0] out_data1, out_data2;
  logic [3:0]   out_tag1, out_tag2;
  logic         one = 1'b1;
`ifdef AES_ROUND_PIPE_PERF_EN
  logic [31:0]  perf_blocks, perf_stalls, pb1, ps1, pb2, ps2;
`endif

  aes_round_pipe #(.PIPE_STAGES(3), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_final(in_final),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef AES_ROUND_PIPE_PERF_EN
    , .perf_blocks(perf_blocks), .perf_stalls(perf_stalls)
`endif
  );

  aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(4)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready1),
    .in_data(in_data), .in_key(in_key), .in_final(in_final),
    .in_tag(in_tag), .out_valid(out_valid1), .out_ready(one),
    .out_data(out_data1), .out_tag(out_tag1)
`ifdef AES_ROUND_PIPE_PERF_EN
    , .perf_blocks(pb1), .perf_stalls(ps1)
`endif
  );

  aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(4)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready2),
    .in_data(in_data), .in_key(in_key), .in_final(in_final),
    .in_tag(in_tag), .out_valid(out_valid2), .out_ready(one),
    .out_data(out_data2), .out_tag(out_tag2)
`ifdef AES_ROUND_PIPE_PERF_EN
    , .perf_blocks(pb2), .perf_stalls(ps2)
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0] gexp [256];
  logic [7:0] glog [256];
  logic [7:0] sb   [256];

  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(int'(glog[a]) + int'(glog[b])) % 255];
  endfunction

  task automatic init_tables();
    logic [7:0] x, v, inv;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = 8'(i);
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
    gexp[255] = gexp[0];
    glog[0] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      inv = (i == 0) ? 8'h00 : gexp[(255 - int'(glog[i])) % 255];
      v = inv;
      sb[i] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
            ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] d,
                                             input logic [127:0] k,
                                             input logic fin);
    logic [7:0] st [4][4];
    logic [7:0] ns [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ns[r][c] = sb[st[r][(c+r)%4]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = fin ? ns[r][c] :
          fmul(8'h02, ns[r][c]) ^ fmul(8'h03, ns[(r+1)%4][c])
          ^ ns[(r+2)%4][c] ^ ns[(r+3)%4][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = st[r][c] ^ k[127-32*c-8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic [3:0]   t;
  } sb_t;
  sb_t sbq[$];

  logic         prev_stall = 1'b0;
  logic [127:0] hold_d;
  logic [3:0]   hold_t;
  int           nxfer = 0;
  int           nstall = 0;

  task automatic step(input logic iv, input logic [127:0] d,
                      input logic [127:0] k, input logic f,
                      input logic [3:0] t, input logic ordy,
                      output logic acc);
    sb_t e;
    @(negedge clk);
    in_valid = iv; in_data = d; in_key = k;
    in_final = f; in_tag = t; out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("stall_hold_data", out_data, hold_d);
      chk("stall_hold_tag", {124'd0, out_tag}, {124'd0, hold_t});
    end
    acc = in_valid && in_ready;
    if (acc) sbq.push_back('{ref_round(d, k, f), t});
    if (out_valid && out_ready) begin
      nxfer++;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got tag %0d data %h want no output",
                 out_tag, out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_tag", {124'd0, out_tag}, {124'd0, e.t});
      end
    end
    if (out_valid && !out_ready) nstall++;
    prev_stall = out_valid && !out_ready;
    hold_d = out_data;
    hold_t = out_tag;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && sbq.size() > 0; i++)
      step(1'b0, '0, '0, 1'b0, 4'd0, 1'b1, acc);
    chk("drain_empty", 128'(sbq.size()), 128'd0);
  endtask

  typedef struct {
    logic [127:0] d;
    logic [127:0] k;
    logic         f;
    logic [3:0]   t;
    logic [127:0] e;
  } vec_t;
  vec_t vt[4];

  task automatic lat_test(input vec_t v);
    int l1, l2, l3;
    logic [127:0] d1, d2, d3;
    logic [3:0] t1, t2, t3;
    l1 = 0; l2 = 0; l3 = 0;
    d1 = '0; d2 = '0; d3 = '0; t1 = 0; t2 = 0; t3 = 0;
    @(negedge clk);
    in_data = v.d; in_key = v.k; in_final = v.f; in_tag = v.t;
    in_valid = 1'b1; in_valid_s = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0; in_valid_s = 1'b0;
      in_key = r128();
      if (out_valid && l3 == 0) begin l3 = c; d3 = out_data; t3 = out_tag; end
      if (out_valid1 && l1 == 0) begin l1 = c; d1 = out_data1; t1 = out_tag1; end
      if (out_valid2 && l2 == 0) begin l2 = c; d2 = out_data2; t2 = out_tag2; end
    end
    chk("lat_p3", 128'(l3), 128'd3);
    chk("data_p3", d3, v.e);
    chk("tag_p3", {124'd0, t3}, {124'd0, v.t});
    chk("lat_p1", 128'(l1), 128'd1);
    chk("data_p1", d1, v.e);
    chk("tag_p1", {124'd0, t1}, {124'd0, v.t});
    chk("lat_p2", 128'(l2), 128'd2);
    chk("data_p2", d2, v.e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic ir4;
    int idx, got0;
    logic [127:0] bd [8];
    logic [127:0] bk [8];
    logic         bf [8];

    init_tables();
    vt[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 4'd5,
              128'ha49c7ff2689f352b6b5bea43026a5049};
    vt[1] = '{128'heb40f21e592e38848ba113e71bc342d2,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 4'd10,
              128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 4; i++) begin
      vt[i].d = r128();
      vt[i].k = r128();
      vt[i].f = i[0];
      vt[i].t = 4'(i + 1);
      vt[i].e = ref_round(vt[i].d, vt[i].k, vt[i].f);
    end

    rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
    in_data = '0; in_key = '0; in_final = 1'b0; in_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_tag", {124'd0, out_tag}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid_p1", {127'd0, out_valid1}, 128'd0);

    for (int i = 0; i < 4; i++) lat_test(vt[i]);

    // backpressure: 8 blocks, out_ready low for cycles 4..9
    for (int i = 0; i < 8; i++) begin
      bd[i] = r128(); bk[i] = r128(); bf[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; got0 = nxfer; ir4 = 1'b1;
    for (int cyc = 0; cyc < 40 && (nxfer - got0) < 8; cyc++) begin
      step(idx < 8, bd[idx%8], bk[idx%8], bf[idx%8], 4'(idx),
           !(cyc >= 4 && cyc <= 9), acc);
      if (cyc == 4) ir4 = in_ready;
      if (acc) idx++;
    end
    chk("bp_in_ready_full", {127'd0, ir4}, 128'd0);
    chk("bp_all_out", 128'(nxfer - got0), 128'd8);
    chk("bp_sb_empty", 128'(sbq.size()), 128'd0);

    // back-to-back, alternating final, new key every cycle
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, r128(), r128(), i[0], 4'(i), 1'b1, acc);
      if (acc) idx++;
    end
    chk("b2b_accepted", 128'(idx), 128'd16);
    drain();

    // random traffic
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), r128(), r128(),
           1'($urandom_range(0, 1)), 4'($urandom),
           $urandom_range(0, 3) != 0, acc);
    drain();

`ifdef AES_ROUND_PIPE_PERF_EN
    chk("perf_blocks", {96'd0, perf_blocks}, 128'(nxfer));
    chk("perf_stalls", {96'd0, perf_stalls}, 128'(nstall));
`endif

    // reset with two blocks in flight
    step(1'b1, r128(), r128(), 1'b0, 4'd9, 1'b1, acc);
    step(1'b1, r128(), r128(), 1'b1, 4'd11, 1'b1, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_out_data", out_data, 128'd0);
    sbq.delete();
    prev_stall = 1'b0; nxfer = 0; nstall = 0;
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 4'd0, 1'b1, acc);
    chk("no_stale_out", 128'(nxfer), 128'd0);
    step(1'b1, vt[0].d, vt[0].k, vt[0].f, vt[0].t, 1'b1, acc);
    drain();
    chk("fresh_after_rst", 128'(nxfer), 128'd1);

`ifdef AES_ROUND_PIPE_PERF_EN
    force u_dut.perf_blocks = 32'hFFFF_FFFE;
    #1;
    release u_dut.perf_blocks;
    step(1'b1, r128(), r128(), 1'b0, 4'd1, 1'b1, acc);
    step(1'b1, r128(), r128(), 1'b0, 4'd2, 1'b1, acc);
    drain();
    step(1'b0, '0, '0, 1'b0, 4'd0, 1'b1, acc);
    chk("perf_sat", {96'd0, perf_blocks}, {96'd0, 32'hFFFF_FFFF});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
